rf_wb_arbiter: RTL



---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/rf_wb_arbiter_wb_fifo.sv | 60 ++++++
 rtl/rf_wb_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg : shared widths and writeback types for the RV32I core slice
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EX   = 2'd1,
    WB_LD   = 2'd2
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo : synchronous FIFO of writeback requests with occupancy output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rstB,
  input  logic                           i_push,
  input  wb_req_t                        i_wdata,
  input  logic                           i_pop,
  output wb_req_t                        o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  wb_req_t         r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  // Guards keep the occupancy register consistent even if a caller misbehaves.
  assign w_push = i_push && (r_count != c_CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rstB) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter : shares the GPR write port between execute and load returns,
//                 with load scoreboard, hazard flag and anti-starvation.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rf_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic              i_ex_valid,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [XLEN-1:0]   i_ex_data,
  output logic              o_ex_stall,
  input  logic              i_ld_issue,
  input  logic [REG_AW-1:0] i_ld_issue_rd,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [REG_AW-1:0] i_ld_rd,
  input  logic [XLEN-1:0]   i_ld_data,
  input  logic [REG_AW-1:0] i_chk_rs1,
  input  logic [REG_AW-1:0] i_chk_rs2,
  input  logic [REG_AW-1:0] i_chk_rd,
  output logic              o_hazard,
  output logic              o_rf_wrEn,
  output logic [REG_AW-1:0] o_rf_wrAddr,
  output logic [XLEN-1:0]   o_rf_wrData
);

  localparam int c_CNT_W = $clog2(LQ_DEPTH+1);
  localparam int c_STV_W = $clog2(STARVE_LIMIT+1);

  logic [c_CNT_W-1:0]  w_count;
  wb_req_t             w_head;
  wb_req_t             w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_ne;
  logic                w_force;
  wb_src_e             w_src;
  logic [c_STV_W-1:0]  r_starve;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;

  assign w_push_req = '{valid: 1'b1, rd: i_ld_rd, data: i_ld_data};
  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign o_ld_ready = rstB && (w_count < c_CNT_W'(LQ_DEPTH));
  assign w_push     = i_ld_valid && o_ld_ready;

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk     (clk),
    .rstB    (rstB),
    .i_push  (w_push),
    .i_wdata (w_push_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_fifo_ne = (w_count != '0);
  assign w_force   = w_fifo_ne && (r_starve == c_STV_W'(STARVE_LIMIT));

  always_comb begin
    w_src = WB_NONE;
    if (rstB) begin
      if (w_force)         w_src = WB_LD;
      else if (i_ex_valid) w_src = WB_EX;
      else if (w_fifo_ne)  w_src = WB_LD;
    end
  end

  assign w_pop      = (w_src == WB_LD);
  assign o_ex_stall = rstB && w_force && i_ex_valid;

  always_comb begin
    o_rf_wrEn   = 1'b0;
    o_rf_wrAddr = i_ex_rd;
    o_rf_wrData = i_ex_data;
    case (w_src)
      WB_EX: o_rf_wrEn = (i_ex_rd != '0);
      WB_LD: begin
        o_rf_wrEn   = w_head.valid && (w_head.rd != '0);
        o_rf_wrAddr = w_head.rd;
        o_rf_wrData = w_head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      r_starve <= '0;
    end else if (w_pop || !w_fifo_ne) begin
      r_starve <= '0;
    end else if ((w_src == WB_EX) && (r_starve != c_STV_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + c_STV_W'(1);
    end
  end

  // Set is applied after clear so a re-issue to a committing register keeps it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.rd] = 1'b0;
    if (i_ld_issue && (i_ld_issue_rd != '0)) w_pending_nxt[i_ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstB) r_pending <= '0;
    else       r_pending <= w_pending_nxt;
  end

  assign o_hazard = rstB && (((i_chk_rs1 != '0) && r_pending[i_chk_rs1]) ||
                             ((i_chk_rs2 != '0) && r_pending[i_chk_rs2]) ||
                             ((i_chk_rd  != '0) && r_pending[i_chk_rd]));

  a_ld_ret_pending: assert property (@(posedge clk) disable iff (!rstB)
    i_ld_valid |-> ((i_ld_rd == '0) || r_pending[i_ld_rd]));

  a_ex_not_pending: assert property (@(posedge clk) disable iff (!rstB)
    (i_ex_valid && (i_ex_rd != '0)) |-> !r_pending[i_ex_rd]);

endmodule

`default_nettype wire
